dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the load/store alignment stage.
- Consumes the word-aligned address, 4-bit byte write-enable and lane-replicated store data; returns the raw 32-bit word for load extraction.
- Models a slow synchronous SRAM with a programmable number of wait states, handshakes with the CPU through req/ready so the MEM stage can stall, and flags out-of-range or misaligned accesses.

---
 rtl/dmem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller placed directly after the load/store
// alignment stage. It models a slow synchronous SRAM of 2^ADDR_WIDTH 32-bit
// words with WAIT_CYCLES programmable wait states, and rejects misaligned or
// out-of-range accesses with a fault response instead of touching the array.
//
// Handshake: the requester raises req with addr/wstrb/wdata and holds them
// until ready. The controller samples the request only in IDLE and latches
// it. ready is a single-cycle completion pulse; fault qualifies that pulse,
// and rdata is valid in the same cycle. The requester drops req, or presents
// the next access, in the cycle after ready.
//
// Ports:
//   clk          in   1   clock, all state changes on the rising edge
//   rst          in   1   synchronous active-high reset
//   req          in   1   access request
//   addr         in  32   byte address (expected word aligned)
//   wstrb        in   4   byte write enables, 0 = read
//   wdata        in  32   lane-replicated store data
//   rdata        out 32   registered read word
//   ready        out  1   one-cycle completion pulse
//   fault        out  1   access rejected (valid with ready)
//   o_dbg_state  out  2   current controller state for observation
module dmem_ctrl #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        fault,
    output logic [1:0]  o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Counter only ever holds WAIT_CYCLES-1 down to 0.
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] WAIT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    // Upper bound evaluated in 33 bits so a window ending at 2^32 does not wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_wstrb;
    logic [31:0]           r_wdata;
    logic                  r_fault;
    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_fault_now;
    logic [ADDR_WIDTH-1:0] w_idx_now;

    assign w_fault_now = (addr[1:0] != 2'b00)
                       || ({1'b0, addr} < {1'b0, BASE_ADDR})
                       || ({1'b0, addr} >= LIMIT);

    // BASE_ADDR is word aligned, so subtracting only the index field gives
    // the same result as (addr - BASE_ADDR)[ADDR_WIDTH+1:2].
    assign w_idx_now = addr[ADDR_WIDTH+1:2] - BASE_ADDR[ADDR_WIDTH+1:2];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        fault        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                ready        = 1'b1;
                fault        = r_fault;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, wait counter and read data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_fault <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_idx   <= w_idx_now;
                        r_wstrb <= wstrb;
                        r_wdata <= wdata;
                        r_fault <= w_fault_now;
                        r_cnt   <= WAIT_INIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACCESS: begin
                    // Writes leave rdata alone; reads and faults update it.
                    if (r_fault) begin
                        r_rdata <= '0;
                    end else if (r_wstrb == 4'b0000) begin
                        r_rdata <= r_mem[r_idx];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage array: not reset; a reset at the ACCESS edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_ACCESS) && !r_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata       = r_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam longint BASE  = 64'h0;
  localparam longint DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v   [3];
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata_v [3];
  logic        ready_v [3];
  logic        fault_v [3];
  logic [1:0]  dbg_v   [3];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of the main instance (WAIT_CYCLES=2)
  logic [31:0] model_mem [int];
  logic [31:0] model_rdata;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst(rst), .req(req_v[0]), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata_v[0]), .ready(ready_v[0]), .fault(fault_v[0]), .o_dbg_state(dbg_v[0])
  );

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req(req_v[1]), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata_v[1]), .ready(ready_v[1]), .fault(fault_v[1]), .o_dbg_state(dbg_v[1])
  );

  dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(5), .BASE_ADDR(32'h0)) u_dut_w5 (
    .clk(clk), .rst(rst), .req(req_v[2]), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .rdata(rdata_v[2]), .ready(ready_v[2]), .fault(fault_v[2]), .o_dbg_state(dbg_v[2])
  );

  // Transaction-level model: one call per completed access.
  function automatic void model_access(input logic [31:0] a, input logic [3:0] s,
                                       input logic [31:0] d, output logic f,
                                       output logic [31:0] rd);
    longint      ua;
    int          idx;
    logic [31:0] w;
    ua = longint'(a);
    f  = ((ua % 4) != 0) || (ua < BASE) || (ua >= BASE + 4 * DEPTH);
    if (f) begin
      model_rdata = 32'h0;
    end else begin
      idx = int'((ua - BASE) / 4);
      if (s != 4'b0000) begin
        w = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++)
          if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model_mem[idx] = w;
      end else begin
        model_rdata = model_mem[idx];
      end
    end
    rd = model_rdata;
  endfunction

  // Driver: issue one access on instance sel, wait (bounded) for ready.
  // lat = number of cycles from acceptance to ready, -1 on timeout.
  task automatic do_access(input int sel, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] d, input bit drop, output int lat,
                           output logic f, output logic [31:0] rd, output logic one_cycle);
    lat = -1; f = 1'b0; rd = 32'h0; one_cycle = 1'b0;
    @(negedge clk);
    addr = a; wstrb = s; wdata = d; req_v[sel] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (drop) req_v[sel] = 1'b0;
      if (ready_v[sel]) begin
        lat = n; f = fault_v[sel]; rd = rdata_v[sel];
        req_v[sel] = 1'b0;
        break;
      end
    end
    req_v[sel] = 1'b0;
    if (lat >= 0) begin
      @(negedge clk);
      one_cycle = !ready_v[sel] && !fault_v[sel];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    addr = 32'h0; wstrb = 4'h0; wdata = 32'h0;
    model_rdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ready_v[i] !== 1'b0 || fault_v[i] !== 1'b0 || rdata_v[i] !== 32'h0 || dbg_v[i] !== 2'd0) begin
        tests_failed++;
        $display("FAIL reset_outputs[%0d]: got ready=%b fault=%b rdata=%h state=%0d want 0/0/0/IDLE",
                 i, ready_v[i], fault_v[i], rdata_v[i], dbg_v[i]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic f, oc; logic [31:0] rd, ef, erd;
    model_access(32'h10, 4'hF, 32'hDEAD_BEEF, ef, erd);
    do_access(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (lat !== 4 || f !== 1'b0 || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_write: got lat=%0d fault=%b one_cycle=%b want 4/0/1", lat, f, oc);
    end
    model_access(32'h10, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'h10, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (lat !== 4 || f !== 1'b0 || rd !== 32'hDEAD_BEEF || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_readback: got lat=%0d fault=%b rdata=%h want 4/0/deadbeef", lat, f, rd);
    end
  endtask

  task automatic test_byte_merge();
    int lat; logic f, oc; logic [31:0] rd, ef, erd;
    model_access(32'h20, 4'hF, 32'h1122_3344, ef, erd);
    do_access(0, 32'h20, 4'hF, 32'h1122_3344, 1'b0, lat, f, rd, oc);
    model_access(32'h20, 4'b0100, 32'hAAAA_AAAA, ef, erd);
    do_access(0, 32'h20, 4'b0100, 32'hAAAA_AAAA, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (rd !== 32'hDEAD_BEEF || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_keeps_rdata: got rdata=%h fault=%b want deadbeef/0", rd, f);
    end
    model_access(32'h20, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'h20, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (rd !== 32'h11AA_3344 || f !== 1'b0) begin
      tests_failed++;
      $display("FAIL byte_merge: got rdata=%h fault=%b want 11aa3344/0", rd, f);
    end
  endtask

  task automatic test_faults();
    int lat; logic f, oc; logic [31:0] rd, ef, erd;
    model_access(32'hFFC, 4'hF, 32'h0BAD_CAFE, ef, erd);
    do_access(0, 32'hFFC, 4'hF, 32'h0BAD_CAFE, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b0 || lat !== 4) begin
      tests_failed++;
      $display("FAIL last_word_write: got fault=%b lat=%0d want 0/4", f, lat);
    end
    model_access(32'h1002, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'h1002, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b1 || rd !== 32'h0 || lat !== 4 || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_oob_read: got fault=%b rdata=%h lat=%0d want 1/0/4", f, rd, lat);
    end
    model_access(32'h1000, 4'hF, 32'h7777_7777, ef, erd);
    do_access(0, 32'h1000, 4'hF, 32'h7777_7777, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b1 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL oob_write: got fault=%b rdata=%h want 1/0", f, rd);
    end
    model_access(32'h11, 4'hF, 32'h9999_9999, ef, erd);
    do_access(0, 32'h11, 4'hF, 32'h9999_9999, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b1) begin
      tests_failed++;
      $display("FAIL misaligned_write: got fault=%b want 1", f);
    end
    model_access(32'hFFFF_FFFC, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'hFFFF_FFFC, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b1 || rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL top_of_space: got fault=%b rdata=%h want 1/0", f, rd);
    end
    model_access(32'hFFC, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'hFFC, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b0 || rd !== 32'h0BAD_CAFE) begin
      tests_failed++;
      $display("FAIL last_word_intact: got fault=%b rdata=%h want 0/0badcafe", f, rd);
    end
    model_access(32'h10, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'h10, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (f !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL word_10_intact: got fault=%b rdata=%h want 0/deadbeef", f, rd);
    end
  endtask

  task automatic test_latency();
    int lat; logic f, oc; logic [31:0] rd;
    do_access(1, 32'h8, 4'hF, 32'hA5A5_0F0F, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (lat !== 2 || f !== 1'b0 || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_w0_write: got lat=%0d fault=%b one_cycle=%b want 2/0/1", lat, f, oc);
    end
    do_access(1, 32'h8, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (lat !== 2 || rd !== 32'hA5A5_0F0F || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_w0_read: got lat=%0d rdata=%h one_cycle=%b want 2/a5a50f0f/1", lat, rd, oc);
    end
    do_access(2, 32'hC, 4'hF, 32'h0102_0304, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (lat !== 7 || f !== 1'b0 || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_w5_write: got lat=%0d fault=%b one_cycle=%b want 7/0/1", lat, f, oc);
    end
    do_access(2, 32'hC, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (lat !== 7 || rd !== 32'h0102_0304 || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL lat_w5_read: got lat=%0d rdata=%h one_cycle=%b want 7/01020304/1", lat, rd, oc);
    end
  endtask

  task automatic test_drop_req();
    int lat; logic f, oc; logic [31:0] rd, ef, erd;
    model_access(32'h24, 4'hF, 32'h6666_1234, ef, erd);
    do_access(0, 32'h24, 4'hF, 32'h6666_1234, 1'b1, lat, f, rd, oc);
    tests_run++;
    if (lat !== 4 || f !== 1'b0 || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_req_write: got lat=%0d fault=%b one_cycle=%b want 4/0/1", lat, f, oc);
    end
    model_access(32'h24, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'h24, 4'h0, 32'h0, 1'b1, lat, f, rd, oc);
    tests_run++;
    if (lat !== 4 || rd !== erd || oc !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_req_read: got lat=%0d rdata=%h want 4/%h", lat, rd, erd);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2; logic f1, f2; logic [31:0] rd2, ef, erd;
    n1 = -1; n2 = -1; f1 = 1'b0; f2 = 1'b0; rd2 = 32'h0;
    model_access(32'h30, 4'hF, 32'hCAFE_F00D, ef, erd);
    @(negedge clk);
    addr = 32'h30; wstrb = 4'hF; wdata = 32'hCAFE_F00D; req_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ready_v[0]) begin
        n1 = n; f1 = fault_v[0];
        addr = 32'h30; wstrb = 4'h0; wdata = $urandom;
        break;
      end
    end
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ready_v[0]) begin
        n2 = n; f2 = fault_v[0]; rd2 = rdata_v[0];
        break;
      end
    end
    req_v[0] = 1'b0;
    model_access(32'h30, 4'h0, 32'h0, ef, erd);
    tests_run++;
    if (n1 !== 4 || f1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d fault=%b want 4/0", n1, f1);
    end
    tests_run++;
    if (n2 !== 5 || f2 !== 1'b0 || rd2 !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL b2b_second: got gap=%0d fault=%b rdata=%h want 5/0/cafef00d", n2, f2, rd2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat; logic f, oc, saw_ready; logic [31:0] rd, ef, erd;
    model_access(32'h40, 4'hF, 32'h1234_5678, ef, erd);
    do_access(0, 32'h40, 4'hF, 32'h1234_5678, 1'b0, lat, f, rd, oc);
    saw_ready = 1'b0;
    @(negedge clk);
    addr = 32'h40; wstrb = 4'hF; wdata = 32'h5555_5555; req_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v[0] = 1'b0;
    saw_ready = saw_ready | ready_v[0];
    @(negedge clk);
    saw_ready = saw_ready | ready_v[0];
    @(negedge clk);
    saw_ready = saw_ready | ready_v[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    tests_run++;
    if (ready_v[0] !== 1'b0 || fault_v[0] !== 1'b0 || rdata_v[0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got ready=%b fault=%b rdata=%h want 0/0/0",
               ready_v[0], fault_v[0], rdata_v[0]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw_ready = saw_ready | ready_v[0];
    end
    tests_run++;
    if (saw_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_ready: got ready pulse=%b want 0", saw_ready);
    end
    model_access(32'h40, 4'h0, 32'h0, ef, erd);
    do_access(0, 32'h40, 4'h0, 32'h0, 1'b0, lat, f, rd, oc);
    tests_run++;
    if (rd !== 32'h1234_5678 || f !== 1'b0 || lat !== 4) begin
      tests_failed++;
      $display("FAIL reset_mid_old_value: got rdata=%h fault=%b lat=%0d want 12345678/0/4", rd, f, lat);
    end
  endtask

  task automatic test_random();
    int lat; logic f, oc, ef; logic [31:0] rd, erd, a, d, exp_rd; logic [3:0] s;
    int r;
    for (int i = 0; i < 8; i++) begin
      a = (32'h100 + 32'(i)) * 4;
      d = $urandom;
      model_access(a, 4'hF, d, ef, erd);
      do_access(0, a, 4'hF, d, 1'b0, lat, f, rd, oc);
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = (32'h100 + $urandom_range(0, 7)) * 4;
      else if (r == 7) a = (32'h100 + $urandom_range(0, 7)) * 4 + $urandom_range(1, 3);
      else if (r == 8) a = 32'h1000 + $urandom_range(0, 255) * 4;
      else             a = 32'hFFFF_FFFC;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d = $urandom;
      model_access(a, s, d, ef, erd);
      exp_q.push_back(erd);
      do_access(0, a, s, d, 1'b0, lat, f, rd, oc);
      exp_rd = exp_q.pop_front();
      tests_run++;
      if (lat !== 4 || f !== ef || rd !== exp_rd || oc !== 1'b1) begin
        tests_failed++;
        $display("FAIL random[%0d] addr=%h wstrb=%h: got lat=%0d fault=%b rdata=%h one_cycle=%b want 4/%b/%h/1",
                 i, a, s, lat, f, rd, oc, ef, exp_rd);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_merge();
    test_faults();
    test_latency();
    test_drop_req();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
